uart_phy: RTL
=============

Name: uart_phy

Overview:
- Serial line PHY sitting directly downstream of the 8250 register-file emulation: consumes its TX byte strobe and produces its RX byte strobe.
- Serialises bytes onto the physical TX pin and deserialises the physical RX pin.
- Fixed 8N1 framing, LSB first, baud rate fixed by parameters (8250 divisor latch not honoured).
- Owns baud timing, input synchronisation, glitch rejection, framing check and a one-byte RX holding buffer.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 115200, line rate in bits/s; BAUD_DIV = CLK_HZ/BAUD (integer, truncated), must be >= 4 and < 65536

Ports:
iClk  in  1  system clock, all logic on rising edge
iRstN  in  1  asynchronous, active-low reset
iTx  in  1  one-cycle strobe: byte on iTxData to transmit
iTxData  in  8  byte to transmit, sampled when iTx accepted
oTxReady  out  1  high when the transmitter is idle and can accept iTx
iRxReady  in  1  consumer can accept a received byte
oRx  out  1  one-cycle strobe: oRxData valid
oRxData  out  8  received byte, held until the next oRx
oFrameErr  out  1  one-cycle pulse: stop bit sampled low
oOverrun  out  1  one-cycle pulse: byte completed while holding buffer full; new byte dropped
iPinRx  in  1  asynchronous serial input, idle high
oPinTx  out  1  serial output, idle high

Behaviour:
- Reset (async, iRstN low): oPinTx=1, oTxReady=1, oRx=0, oRxData=0, oFrameErr=0, oOverrun=0, RX sync flops=1, both FSMs to IDLE, holding buffer empty, counters 0. Reset mid-frame aborts the frame immediately; no partial byte is delivered.
- TX FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE.
  - IDLE: oTxReady=1, oPinTx=1. iTx && oTxReady latches iTxData. oTxReady=0 and oPinTx=0 from the next cycle.
  - Each bit lasts exactly BAUD_DIV cycles. Data bits go out LSB first. Stop bit is 1.
  - oTxReady returns to 1 on the cycle after the stop bit completes. Total frame = 10*BAUD_DIV cycles.
  - iTx while oTxReady=0 is ignored.
  - iTx in the same cycle oTxReady rises is accepted.
- RX input: iPinRx passes through a 2-flop synchroniser (2-cycle latency). All RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, plus a WAIT_HIGH state.
  - IDLE: synced low -> START, counter = BAUD_DIV/2.
  - START: at counter expiry, synced still low -> DATA (counter = BAUD_DIV). Synced high -> IDLE; glitch rejected, no flags.
  - DATA: sample at each expiry of BAUD_DIV, shift in LSB first, 8 samples, then STOP.
  - STOP: sample after BAUD_DIV.
    - High: byte completes; go to IDLE.
    - Low: oFrameErr pulses, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until synced high, then IDLE. A break condition yields a single oFrameErr.
- Holding buffer (one byte):
  - On byte completion with buffer empty: store the byte and mark the buffer full.
  - On byte completion with buffer full: oOverrun pulses, new byte dropped, buffer unchanged.
  - Delivery: buffer full && iRxReady -> oRx=1 for one cycle, oRxData=buffer, buffer empty that same edge.
  - Byte completion and delivery in the same cycle: the delivered (old) byte goes out, the new byte is stored, no overrun.
  - Minimum latency from mid-stop-bit sample to oRx: 1 cycle, if iRxReady is high.
- TX and RX are fully independent; simultaneous activity on both is required to work.
- Counter width: 16 bits. No arithmetic beyond decrement-to-zero reload.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (BAUD_DIV=10); iTx with iTxData=0xA5 -> oTxReady low next cycle. oPinTx sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. oTxReady high 100 cycles after acceptance. Second iTx mid-frame with 0xFF is ignored.
- Drive iPinRx frame for 0x3C at 10 cycles/bit with iRxReady=1 -> exactly one oRx pulse, oRxData=0x3C, no oFrameErr, no oOverrun.
- iRxReady=0; send 0x11 then 0x22 -> oOverrun pulses once at the end of the second frame. Then raise iRxReady -> single oRx with oRxData=0x11.
- Frame 0x55 with stop bit driven low, line held low for 30 bit-times -> exactly one oFrameErr, no oRx. After the line returns high, frame 0x0F is received correctly.
- 3-cycle low glitch on iPinRx -> no oRx, no oFrameErr; FSM back in IDLE.
- Assert iRstN low mid-TX-frame and mid-RX-frame -> oPinTx=1 and oTxReady=1 immediately. No oRx after release. A subsequent 0x81 transmits and receives cleanly.

Source files
------------

// File: rtl/uart_phy.sv
// uart_phy: fixed-baud 8N1 UART serialiser/deserialiser with input sync, glitch rejection, framing check and one-byte RX holding buffer
module uart_phy #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iTx,
  input  logic [7:0] iTxData,
  output logic       oTxReady,
  input  logic       iRxReady,
  output logic       oRx,
  output logic [7:0] oRxData,
  output logic       oFrameErr,
  output logic       oOverrun,
  input  logic       iPinRx,
  output logic       oPinTx
);
  localparam logic [15:0] DIV  = 16'(CLK_HZ / BAUD);
  localparam logic [15:0] HALF = 16'(CLK_HZ / BAUD / 2);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        s1_q, s2_q;
  logic        rx_exp, done, ferr, deliver;
  logic [7:0]  buf_q, buf_d, data_q, data_d;
  logic        full_q, full_d, rx_q, rx_d, fe_q, ovr_q, ovr_d;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    if (tx_state_q == T_IDLE) begin
      if (iTx) begin
        tx_state_d = T_START;
        tx_cnt_d   = DIV;
        tx_bit_d   = 3'd0;
        tx_sh_d    = iTxData;
      end
    end else if (tx_cnt_q != 16'd1) begin
      tx_cnt_d = tx_cnt_q - 16'd1;
    end else begin
      tx_cnt_d = DIV;
      case (tx_state_q)
        T_START: tx_state_d = T_DATA;
        T_DATA: begin
          tx_sh_d    = tx_sh_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_state_d = tx_bit_q == 3'd7 ? T_STOP : T_DATA;
        end
        default: begin
          tx_state_d = T_IDLE;
          tx_cnt_d   = 16'd0;
        end
      endcase
    end
  end
  assign oTxReady = tx_state_q == T_IDLE;
  assign oPinTx   = tx_state_q == T_START ? 1'b0 : tx_state_q == T_DATA ? tx_sh_q[0] : 1'b1;
  assign rx_exp = rx_cnt_q == 16'd1;
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    done       = 1'b0;
    ferr       = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!s2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = HALF;
        end
      end
      R_START: begin
        if (rx_exp) begin
          rx_state_d = s2_q ? R_IDLE : R_DATA;
          rx_cnt_d   = s2_q ? 16'd0 : DIV;
          rx_bit_d   = 3'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      R_DATA: begin
        if (rx_exp) begin
          rx_sh_d    = {s2_q, rx_sh_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_cnt_d   = DIV;
          rx_state_d = rx_bit_q == 3'd7 ? R_STOP : R_DATA;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      R_STOP: begin
        if (rx_exp) begin
          done       = s2_q;
          ferr       = !s2_q;
          rx_state_d = s2_q ? R_IDLE : R_WAIT;
          rx_cnt_d   = 16'd0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = s2_q ? R_IDLE : R_WAIT;
    endcase
  end
  assign deliver = full_q & iRxReady;
  always_comb begin
    rx_d   = deliver | (done & !full_q & iRxReady);
    data_d = deliver ? buf_q : rx_d ? rx_sh_q : data_q;
    full_d = deliver ? done : full_q | (done & !iRxReady);
    buf_d  = done & (deliver | (!full_q & !iRxReady)) ? rx_sh_q : buf_q;
    ovr_d  = done & full_q & !iRxReady;
  end
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'd0;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      buf_q      <= 8'd0;
      full_q     <= 1'b0;
      rx_q       <= 1'b0;
      data_q     <= 8'd0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      s1_q       <= iPinRx;
      s2_q       <= s1_q;
      buf_q      <= buf_d;
      full_q     <= full_d;
      rx_q       <= rx_d;
      data_q     <= data_d;
      fe_q       <= ferr;
      ovr_q      <= ovr_d;
    end
  end
  assign oRx       = rx_q;
  assign oRxData   = data_q;
  assign oFrameErr = fe_q;
  assign oOverrun  = ovr_q;
endmodule
